// File: rtl/cache_pkg.sv
// Shared state encoding, classification codes and strobe decode for the L1/L2/memory sequencer.
package cache_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_L1_REQ,
    ST_L1_CHK,
    ST_L2_REQ,
    ST_L2_CHK,
    ST_MEM,
    ST_FILL_L2,
    ST_FILL_L1,
    ST_RESP
  } state_e;

  // One-hot response classification: bit0 L1 hit, bit1 L2 hit, bit2 miss.
  localparam logic [2:0] CLS_NONE = 3'b000;
  localparam logic [2:0] CLS_L1   = 3'b001;
  localparam logic [2:0] CLS_L2   = 3'b010;
  localparam logic [2:0] CLS_MISS = 3'b100;

  typedef struct packed {
    logic req_ready;
    logic resp_valid;
    logic l1_lookup;
    logic l2_lookup;
    logic l1_fill;
    logic l2_fill;
    logic mem_req;
  } ctl_t;

  function automatic ctl_t ctl_decode(state_e s);
    ctl_t c;
    c = '0;
    case (s)
      ST_IDLE:    c.req_ready  = 1'b1;
      ST_L1_REQ:  c.l1_lookup  = 1'b1;
      ST_L2_REQ:  c.l2_lookup  = 1'b1;
      ST_MEM:     c.mem_req    = 1'b1;
      ST_FILL_L2: c.l2_fill    = 1'b1;
      ST_FILL_L1: c.l1_fill    = 1'b1;
      ST_RESP:    c.resp_valid = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cache_stat_cnt.sv
// Saturating event counter: one cycle from inc to updated count, holds at all-ones.
module cache_stat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cache_hier_ctrl.sv
// Sequences L1 probe, L2 probe, memory fetch and fills for one request at a time.
// Response 3 / 6 / 7+N edges after accept; req_ready low and response held until resp_ready.
module cache_hier_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_l1_hit,
  output logic              resp_l2_hit,
  output logic              resp_miss,
  output logic              l1_lookup,
  input  logic              l1_hit,
  output logic              l2_lookup,
  input  logic              l2_hit,
  output logic              l1_fill,
  output logic              l2_fill,
  output logic [ADDR_W-1:0] cache_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  l1_hit_cnt,
  output logic [CNT_W-1:0]  l2_hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  state_e            state_q, state_d;
  ctl_t              ctl_q, ctl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        cls_q, cls_d;
  logic              resp_fire;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cls_d   = cls_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          state_d = ST_L1_REQ;
        end
      end
      ST_L1_REQ: state_d = ST_L1_CHK;
      ST_L1_CHK: begin
        if (l1_hit) begin
          cls_d   = CLS_L1;
          state_d = ST_RESP;
        end else begin
          state_d = ST_L2_REQ;
        end
      end
      ST_L2_REQ: state_d = ST_L2_CHK;
      ST_L2_CHK: begin
        // An L2 hit skips the L2 fill and only promotes the line into L1.
        if (l2_hit) begin
          cls_d   = CLS_L2;
          state_d = ST_FILL_L1;
        end else begin
          cls_d   = CLS_MISS;
          state_d = ST_MEM;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          state_d = ST_FILL_L2;
        end
      end
      ST_FILL_L2: state_d = ST_FILL_L1;
      ST_FILL_L1: state_d = ST_RESP;
      ST_RESP: begin
        if (resp_ready) begin
          cls_d   = CLS_NONE;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are registered decodes of the next state, so they are glitch-free Moore outputs.
  assign ctl_d = ctl_decode(state_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ctl_q   <= ctl_decode(ST_IDLE);
      addr_q  <= '0;
      cls_q   <= CLS_NONE;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      addr_q  <= addr_d;
      cls_q   <= cls_d;
    end
  end

  assign req_ready   = ctl_q.req_ready;
  assign resp_valid  = ctl_q.resp_valid;
  assign l1_lookup   = ctl_q.l1_lookup;
  assign l2_lookup   = ctl_q.l2_lookup;
  assign l1_fill     = ctl_q.l1_fill;
  assign l2_fill     = ctl_q.l2_fill;
  assign mem_req     = ctl_q.mem_req;
  assign cache_addr  = addr_q;
  assign resp_l1_hit = cls_q[0];
  assign resp_l2_hit = cls_q[1];
  assign resp_miss   = cls_q[2];

  assign resp_fire = (state_q == ST_RESP) && resp_ready;

  cache_stat_cnt #(.W(CNT_W)) u_l1_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (resp_fire && (cls_q == CLS_L1)),
    .cnt   (l1_hit_cnt)
  );

  cache_stat_cnt #(.W(CNT_W)) u_l2_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (resp_fire && (cls_q == CLS_L2)),
    .cnt   (l2_hit_cnt)
  );

  cache_stat_cnt #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (resp_fire && (cls_q == CLS_MISS)),
    .cnt   (miss_cnt)
  );

endmodule

// File: doc/cache_hier_ctrl.md
Name: cache_hier_ctrl

Overview:
- Sequencing controller for the two-level direct-mapped hierarchy: the L1 cache, the L2 cache and the main-memory port.
- Accepts one address request at a time over a valid/ready handshake.
- Probes L1, then L2 on an L1 miss, then memory on an L2 miss.
- Promotes L2 hits into L1, fills both levels on a memory miss, and returns a one-hot hit classification. Keeps saturating hit/miss statistics counters.
- Sits between the core-side address source and the cache_direct / cache_directl2 instances.

Parameters:
- ADDR_W, 11, address width for all address ports.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  requester presents req_addr.
- req_addr  in  ADDR_W  requested address.
- req_ready  out  1  controller can accept a request.
- resp_valid  out  1  classification valid; held until resp_ready.
- resp_ready  in  1  requester consumes the response.
- resp_l1_hit  out  1  the request hit in L1.
- resp_l2_hit  out  1  the request missed L1 and hit L2.
- resp_miss  out  1  the request missed both levels.
- l1_lookup  out  1  one-cycle L1 probe strobe.
- l1_hit  in  1  L1 hit result, valid the cycle after l1_lookup.
- l2_lookup  out  1  one-cycle L2 probe strobe.
- l2_hit  in  1  L2 hit result, valid the cycle after l2_lookup.
- l1_fill  out  1  one-cycle L1 line install strobe.
- l2_fill  out  1  one-cycle L2 line install strobe.
- cache_addr  out  ADDR_W  latched request address; drives both caches' probe and fill address.
- mem_req  out  1  memory read request; held until mem_ack.
- mem_ack  in  1  memory completion pulse.
- l1_hit_cnt, l2_hit_cnt, miss_cnt  out  CNT_W each  saturating statistics counters.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - State returns to IDLE.
  - All strobes, mem_req, resp_valid and resp_* are 0.
  - cache_addr and all counters are 0.
  - req_ready is 1.
- Outputs are Moore decodes of a registered state. cache_addr and the resp_* flags are registered.
- States and transitions:
  - IDLE: req_ready=1. On req_valid, latch req_addr into cache_addr and go to L1_REQ.
  - L1_REQ: l1_lookup=1. Go to L1_CHK.
  - L1_CHK: sample l1_hit. If hit: set resp_l1_hit, go to RESP. Otherwise go to L2_REQ.
  - L2_REQ: l2_lookup=1. Go to L2_CHK.
  - L2_CHK: sample l2_hit. If hit: set resp_l2_hit, go to FILL_L1 (promotion). Otherwise set resp_miss, go to MEM.
  - MEM: mem_req=1. Stay until mem_ack=1, then go to FILL_L2.
  - FILL_L2: l2_fill=1. Go to FILL_L1.
  - FILL_L1: l1_fill=1. Go to RESP.
  - RESP: resp_valid=1. On resp_ready: increment exactly one counter matching the classification, clear resp_*, go to IDLE.
- Latency, counted in edges from the accept edge to resp_valid high:
  - L1 hit: 3.
  - L2 hit: 6.
  - Miss: 7 + N, where N is the number of MEM cycles before the mem_ack edge (N≥1).
- req_ready is 0 in every state except IDLE. At most one request is outstanding.
- Back-to-back requests: a request may be accepted in the IDLE cycle immediately after the RESP handshake.
- Fill ordering: l2_fill always precedes l1_fill, in consecutive cycles. Each is exactly one cycle wide.
- Strobe exclusivity: the resp_* flags are mutually exclusive. At most one of l1_lookup, l2_lookup, l1_fill, l2_fill, mem_req is high in any cycle.
- Ignored inputs:
  - l1_hit outside L1_CHK, l2_hit outside L2_CHK, and mem_ack outside MEM are ignored.
  - A mem_ack coinciding with mem_req's first cycle is accepted.
- Counters hold at 2^CNT_W−1; no wrap.
- cache_addr holds stable from accept until IDLE is re-entered.
- Reset mid-operation (e.g. during MEM or RESP):
  - Immediate return to IDLE; all strobes and mem_req drop asynchronously.
  - The in-flight request is discarded; no counter updates.
  - A subsequent late mem_ack is ignored.

Decomposition:
- Shared package cache_pkg holds:
  - the state encoding enum for the states above;
  - ADDR_W default 11;
  - classification constants CLS_L1, CLS_L2, CLS_MISS.
- One natural sub-module: cache_stat_cnt, a single saturating counter with inc and rst_n inputs, instantiated three times.

Test Plan:
1. L1 hit: after reset, req addr 0x1A4 with l1_hit=1 in L1_CHK -> resp_valid at accept+3, resp_l1_hit=1, no fill/mem strobes, l1_hit_cnt=1.
2. L2 hit with promotion: addr 0x3F0, l1_hit=0, l2_hit=1 -> single l1_fill pulse, cache_addr=0x3F0, resp at accept+6, resp_l2_hit=1, l2_hit_cnt=1.
3. Full miss: addr 0x7FF, both hits 0, mem_ack after 5 MEM cycles -> mem_req high 5 cycles, then l2_fill, then l1_fill, resp_miss=1 at accept+12, miss_cnt=1.
4. Backpressure and back-to-back: hold resp_ready=0 for 4 cycles -> resp_valid and flags stable, req_ready=0. Release, then a new request the next cycle is accepted.
5. Reset mid-MEM: assert rst_n=0 during MEM -> mem_req drops without waiting for clk, state IDLE, counters unchanged. A stray mem_ack afterwards produces no response.
6. Saturation with CNT_W=2: 5 L1-hit transactions -> l1_hit_cnt sticks at 3; other counters 0.
